// File: rtl/decoder3_8_triple.sv
// Three independent 3-to-8 one-hot decoder lanes with a clocked lane-agreement monitor.
// Optional macro DEC38_OUTREG_EN registers the decoded outputs (one-cycle latency).
module decoder3_8_triple #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       a_sv,
    output logic [7:0]       y_sv,
    input  logic [2:0]       a_v,
    output logic [7:0]       y_v,
    input  logic [2:0]       a_vhd,
    output logic [7:0]       y_vhd,
    output logic             lanes_agree,
    output logic             disagree_seen,
    output logic [CNT_W-1:0] disagree_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Any unknown code bit falls through to the default branch and yields all zeros.
    function automatic logic [7:0] dec3_8(input logic [2:0] code);
        logic [7:0] onehot_s;
        case (code)
            3'd0:    onehot_s = 8'b0000_0001;
            3'd1:    onehot_s = 8'b0000_0010;
            3'd2:    onehot_s = 8'b0000_0100;
            3'd3:    onehot_s = 8'b0000_1000;
            3'd4:    onehot_s = 8'b0001_0000;
            3'd5:    onehot_s = 8'b0010_0000;
            3'd6:    onehot_s = 8'b0100_0000;
            3'd7:    onehot_s = 8'b1000_0000;
            default: onehot_s = 8'h00;
        endcase
        return onehot_s;
    endfunction

    logic [7:0]       dec_sv_s;
    logic [7:0]       dec_v_s;
    logic [7:0]       dec_vhd_s;
    logic             agree_s;
    logic             seen_r;
    logic [CNT_W-1:0] cnt_r;

    // Per-lane decode; each lane calls its own copy of the decoder.
    always_comb begin
        dec_sv_s  = dec3_8(a_sv);
        dec_v_s   = dec3_8(a_v);
        dec_vhd_s = dec3_8(a_vhd);
    end

    // An unknown comparison result takes the else branch, so X/Z reads as disagreement.
    always_comb begin
        agree_s = 1'b0;
        if ((a_sv == a_v) && (a_v == a_vhd)) begin
            agree_s = 1'b1;
        end else begin
            agree_s = 1'b0;
        end
    end

    // Sticky disagreement flag and saturating disagreement counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_r <= 1'b0;
            cnt_r  <= '0;
        end else if (!agree_s) begin
            seen_r <= 1'b1;
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            seen_r <= seen_r;
            cnt_r  <= cnt_r;
        end
    end

`ifdef DEC38_OUTREG_EN
    logic [7:0] y_sv_r;
    logic [7:0] y_v_r;
    logic [7:0] y_vhd_r;

    // Output registers for the decoded lanes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_sv_r  <= 8'h00;
            y_v_r   <= 8'h00;
            y_vhd_r <= 8'h00;
        end else begin
            y_sv_r  <= dec_sv_s;
            y_v_r   <= dec_v_s;
            y_vhd_r <= dec_vhd_s;
        end
    end

    assign y_sv  = y_sv_r;
    assign y_v   = y_v_r;
    assign y_vhd = y_vhd_r;
`else
    assign y_sv  = dec_sv_s;
    assign y_v   = dec_v_s;
    assign y_vhd = dec_vhd_s;
`endif

    assign lanes_agree   = agree_s;
    assign disagree_seen = seen_r;
    assign disagree_cnt  = cnt_r;

endmodule

// File: tb/tb_decoder3_8_triple.sv
// Randomized self-checking bench for decoder3_8_triple against a behavioural model;
// a second instance with CNT_W = 2 exercises counter saturation.
module tb_decoder3_8_triple;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] a_sv, a_v, a_vhd;

    logic [7:0] y_sv, y_v, y_vhd;
    logic       lanes_agree, disagree_seen;
    logic [7:0] disagree_cnt;

    logic [7:0] s_y_sv, s_y_v, s_y_vhd;
    logic       s_agree, s_seen;
    logic [1:0] s_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         m_seen;
    int         m_cnt;
    int         m_cnt2;
    logic [7:0] m_y_sv, m_y_v, m_y_vhd;

    decoder3_8_triple #(.CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_sv(a_sv), .y_sv(y_sv), .a_v(a_v), .y_v(y_v), .a_vhd(a_vhd), .y_vhd(y_vhd),
        .lanes_agree(lanes_agree), .disagree_seen(disagree_seen), .disagree_cnt(disagree_cnt)
    );

    decoder3_8_triple #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .a_sv(a_sv), .y_sv(s_y_sv), .a_v(a_v), .y_v(s_y_v), .a_vhd(a_vhd), .y_vhd(s_y_vhd),
        .lanes_agree(s_agree), .disagree_seen(s_seen), .disagree_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_dec(input logic [2:0] a);
        if ($isunknown(a)) return 8'h00;
        return 8'h01 << a;
    endfunction

    function automatic bit ref_agree(input logic [2:0] x, input logic [2:0] y, input logic [2:0] z);
        if ($isunknown({x, y, z})) return 1'b0;
        return (x === y) && (y === z);
    endfunction

    function automatic logic [7:0] exp_y(input int lane);
        logic [2:0] a;
        logic [7:0] yr;
        a  = (lane == 0) ? a_sv : (lane == 1) ? a_v : a_vhd;
        yr = (lane == 0) ? m_y_sv : (lane == 1) ? m_y_v : m_y_vhd;
`ifdef DEC38_OUTREG_EN
        return yr;
`else
        return ref_dec(a);
`endif
    endfunction

    task automatic check_all(input string tag);
        check_val({tag, "_y_sv"},   32'(y_sv),          32'(exp_y(0)));
        check_val({tag, "_y_v"},    32'(y_v),           32'(exp_y(1)));
        check_val({tag, "_y_vhd"},  32'(y_vhd),         32'(exp_y(2)));
        check_val({tag, "_agree"},  32'(lanes_agree),   32'(ref_agree(a_sv, a_v, a_vhd)));
        check_val({tag, "_seen"},   32'(disagree_seen), 32'(m_seen));
        check_val({tag, "_cnt"},    32'(disagree_cnt),  32'(m_cnt));
        check_val({tag, "_s_seen"}, 32'(s_seen),        32'(m_seen));
        check_val({tag, "_s_cnt"},  32'(s_cnt),         32'(m_cnt2));
    endtask

    task automatic apply(input logic [2:0] x, input logic [2:0] y, input logic [2:0] z);
        a_sv = x; a_v = y; a_vhd = z;
    endtask

    // One rising edge; model follows the rules with the inputs held across the edge.
    task automatic step();
        @(posedge clk);
        if (reset_n) begin
            if (!ref_agree(a_sv, a_v, a_vhd)) begin
                m_seen = 1'b1;
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            m_y_sv  = ref_dec(a_sv);
            m_y_v   = ref_dec(a_v);
            m_y_vhd = ref_dec(a_vhd);
        end
        #1;
    endtask

    task automatic model_reset();
        m_seen = 1'b0; m_cnt = 0; m_cnt2 = 0;
        m_y_sv = 8'h00; m_y_v = 8'h00; m_y_vhd = 8'h00;
    endtask

    // Called between edges: reset is asynchronous and outputs must react immediately.
    task automatic pulse_reset(input string tag);
        #1 reset_n = 1'b0;
        #1 model_reset();
        check_all({tag, "_in"});
        a_sv = a_sv + 3'd1;
        #1 check_all({tag, "_follow"});
        #1 reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        reset_n = 1'b0;
        apply(3'd0, 3'd0, 3'd0);
        @(negedge clk);
        check_all("reset");
        reset_n = 1'b1;
        step();

        // Exhaustive sweep, all lanes equal
        for (int k = 0; k < 8; k++) begin
            apply(3'(k), 3'(k), 3'(k));
            @(negedge clk);
            check_all("sweep");
            step();
        end
        @(negedge clk);
`ifndef DEC38_OUTREG_EN
        check_val("sweep_last_y", 32'(y_sv), 32'h80);
`endif
        check_val("sweep_cnt0", 32'(disagree_cnt), 32'd0);
        step();

        // Independent lanes for three clocks
        apply(3'd1, 3'd6, 3'd2);
        @(negedge clk);
        check_all("indep");
`ifndef DEC38_OUTREG_EN
        check_val("indep_y_sv", 32'(y_sv), 32'h02);
        check_val("indep_y_v", 32'(y_v), 32'h40);
        check_val("indep_y_vhd", 32'(y_vhd), 32'h04);
`endif
        check_val("indep_agree", 32'(lanes_agree), 32'd0);
        repeat (3) step();
        @(negedge clk);
        check_val("indep_seen", 32'(disagree_seen), 32'd1);
        check_val("indep_cnt3", 32'(disagree_cnt), 32'd3);
        check_all("indep_after");

        // Reset mid-run after a count of two
        pulse_reset("rst_a");
        apply(3'd5, 3'd5, 3'd0);
        repeat (2) step();
        @(negedge clk);
        check_val("mid_cnt2", 32'(disagree_cnt), 32'd2);
        pulse_reset("rst_mid");
        check_val("mid_cnt_cleared", 32'(disagree_cnt), 32'd0);
        check_val("mid_seen_cleared", 32'(disagree_seen), 32'd0);

        // Saturation: six disagreeing clocks
        apply(3'd0, 3'd7, 3'd3);
        repeat (6) step();
        @(negedge clk);
        check_val("sat_cnt2w", 32'(s_cnt), 32'd3);
        check_val("sat_cnt8w", 32'(disagree_cnt), 32'd6);
        check_all("sat");
        step();

        // Unknown code on one lane
        apply(3'bxxx, 3'd4, 3'd4);
        @(negedge clk);
        check_all("unknown");
        step();

        // Output latency: code 7 on all lanes
        apply(3'd7, 3'd7, 3'd7);
        step();
        @(negedge clk);
        check_val("lat7_y", 32'(y_v), 32'h80);
        step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [2:0] c;
            r = $urandom_range(0, 9);
            c = 3'($urandom_range(0, 7));
            if (r < 5)      apply(c, c, c);
            else if (r < 9) apply(c, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            else            apply(c, 3'bxxx, c);
            @(negedge clk);
            check_all("rand");
            if ($urandom_range(0, 39) == 0) pulse_reset("rand_rst");
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder3_8_triple.md
Name: decoder3_8_triple

Overview:
- Three independent 3-to-8 one-hot decoder lanes (sv, v, vhd) in one top block, used as a cross-implementation equivalence wrapper.
- Each lane maps a 3-bit code to an 8-bit one-hot word, combinationally by default.
- A clocked monitor compares the three lane inputs every cycle and keeps a sticky disagreement flag and a saturating disagreement counter for bring-up and debug.

Parameters:
- CNT_W, 8, width of the saturating disagreement counter (legal range 1..32).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- a_sv  input  3  sv lane code.
- y_sv  output  8  sv lane one-hot decode.
- a_v  input  3  v lane code.
- y_v  output  8  v lane one-hot decode.
- a_vhd  input  3  vhd lane code.
- y_vhd  output  8  vhd lane one-hot decode.
- lanes_agree  output  1  combinational; 1 when a_sv == a_v == a_vhd.
- disagree_seen  output  1  sticky; set on any clock edge where lanes_agree = 0.
- disagree_cnt  output  CNT_W  number of clocks with lanes_agree = 0, saturating.

Behaviour:
- Decode rule, identical for every lane: y[k] = 1 iff a == k, for k = 0..7.
  - Exactly one bit of y is set for any fully known input.
  - 0 -> 8'b0000_0001, 3 -> 8'b0000_1000, 7 -> 8'b1000_0000.
- Input containing any X or Z bit: that lane's y drives 8'h00 (case default branch). Other lanes are unaffected.
- Default build: decode is purely combinational, zero latency. y follows a within the same delta and is independent of clk and reset_n.
- Lanes share no logic. Each lane's output depends only on its own input.
- lanes_agree is combinational. Any X/Z on an input makes lanes_agree = 0.
- Monitor, on the rising edge of clk:
  - lanes_agree = 0 sets disagree_seen to 1.
  - lanes_agree = 0 also increments disagree_cnt unless it equals 2^CNT_W-1; at that value it holds (saturates, no wrap).
  - disagree_seen clears only on reset.
- Reset (reset_n = 0, asynchronous, takes effect immediately, also mid-operation):
  - disagree_seen = 0, disagree_cnt = 0.
  - y_* unaffected in the default build.
- Reset asserted together with a disagreeing edge: reset wins, so state stays 0.

Optional Feature:
- Macro DEC38_OUTREG_EN.
- Defined:
  - y_sv, y_v and y_vhd are registered on the rising edge of clk, giving one-cycle latency from a_* to y_*.
  - reset_n asynchronously clears all three registers to 8'h00.
  - The X/Z input case registers 8'h00.
  - Monitor behaviour is unchanged and still compares the unregistered inputs.
- Undefined: combinational outputs as described in Behaviour.

Test Plan:
- Exhaustive sweep: apply 0..7 to all three lanes together, one code per cycle, inputs changed on the rising edge and checked on the falling edge. Required: each y = 1<<a, e.g. a = 5 -> 8'h20. lanes_agree = 1, disagree_cnt stays 0.
- Independent lanes: a_sv = 1, a_v = 6, a_vhd = 2. Required: y_sv = 8'h02, y_v = 8'h40, y_vhd = 8'h04, lanes_agree = 0. After 3 clocks, disagree_seen = 1 and disagree_cnt = 3.
- Unknown input: a_sv = 3'bZZZ with other lanes at 4. Required: y_sv = 8'h00, y_v = y_vhd = 8'h10, lanes_agree = 0.
- Saturation with CNT_W = 2: hold disagreement for 6 clocks. Required: disagree_cnt = 3, no wrap to 0.
- Reset mid-run: after disagree_cnt = 2, pulse reset_n low between clock edges. Required: immediate disagree_seen = 0 and disagree_cnt = 0. y outputs keep following inputs (default build).
- With DEC38_OUTREG_EN defined: apply a = 7 at edge n. Required: y = 8'h80 visible after edge n+1; y = 8'h00 while reset_n = 0.
